// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - state encoding and default sweep parameters
package sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } sweep_state_t;

  localparam int DEF_START_INDEX = 1;
  localparam int DEF_STEP        = 1;
  localparam int DEF_INDEX_MAX   = 2751;
  localparam int DEF_FTW_PER_BIN = 34360;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchroniser with level and registered rising-edge outputs
module sync_edge_det (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic sync1, sync2, sync3;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      sync3 <= sync2;
      rise  <= sync2 & ~sync3;
    end
  end

  assign level = sync2;

endmodule

// File: rtl/sweep_freq_gen.sv
// rtl/sweep_freq_gen.sv - stepped FFT-bin sweep generator driving a DDS tuning word
module sweep_freq_gen
  import sweep_pkg::*;
#(
  parameter int START_INDEX = DEF_START_INDEX,
  parameter int STEP        = DEF_STEP,
  parameter int INDEX_MAX   = DEF_INDEX_MAX,
  parameter int FTW_PER_BIN = DEF_FTW_PER_BIN
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        learn_en,
  input  logic        next_freq,
  output logic [15:0] freq,
  output logic [31:0] ftw,
  output logic        ftw_valid,
  output logic        dds_en,
  output logic        sweep_done
);

  localparam logic [15:0] START_W = 16'(START_INDEX);
  localparam logic [15:0] STEP_W  = 16'(STEP);
  localparam logic [15:0] MAX_W   = 16'(INDEX_MAX);
  localparam logic [31:0] BIN_FTW = 32'(FTW_PER_BIN);

  sweep_state_t state, state_nxt;
  logic         learn_lvl, learn_rise;
  logic         next_lvl, next_rise;
  logic         unused_sync;
  logic         pending;
  logic         calc_last;
  logic         req;
  logic [16:0]  freq_sum;
  logic [15:0]  freq_step;
  logic [31:0]  prod_lo;
  logic [31:0]  prod;

  sync_edge_det u_learn_sync (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .async_in (learn_en),
    .level    (learn_lvl),
    .rise     (learn_rise)
  );

  sync_edge_det u_next_sync (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .async_in (next_freq),
    .level    (next_lvl),
    .rise     (next_rise)
  );

  assign unused_sync = learn_rise ^ next_lvl;

  assign req       = next_rise | pending;
  assign freq_sum  = {1'b0, freq} + {1'b0, STEP_W};
  assign freq_step = (freq == 16'd0)              ? START_W :
                     (freq_sum >= {1'b0, MAX_W})  ? MAX_W   : freq_sum[15:0];
  // Only the low 32 bits of the product matter: the tuning word wraps mod 2^32.
  assign prod_lo   = 32'(freq) * BIN_FTW;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!learn_lvl) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_HOLD;
        ST_HOLD: if (req) state_nxt = ST_CALC;
        ST_CALC: if (calc_last) state_nxt = (freq == MAX_W) ? ST_DONE : ST_HOLD;
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      freq       <= '0;
      ftw        <= '0;
      ftw_valid  <= 1'b0;
      dds_en     <= 1'b0;
      sweep_done <= 1'b0;
      pending    <= 1'b0;
      calc_last  <= 1'b0;
      prod       <= '0;
    end else begin
      ftw_valid <= 1'b0;
      // Dropping learn_en wins over everything, including a CALC about to publish.
      if (!learn_lvl || state == ST_IDLE) begin
        freq       <= '0;
        ftw        <= '0;
        dds_en     <= 1'b0;
        sweep_done <= 1'b0;
        pending    <= 1'b0;
        calc_last  <= 1'b0;
        prod       <= '0;
      end else begin
        case (state)
          ST_HOLD: begin
            if (req) begin
              freq      <= freq_step;
              pending   <= 1'b0;
              calc_last <= 1'b0;
            end
          end
          ST_CALC: begin
            if (next_rise) pending <= 1'b1;
            if (!calc_last) begin
              prod      <= prod_lo;
              calc_last <= 1'b1;
            end else begin
              ftw       <= prod;
              ftw_valid <= 1'b1;
              calc_last <= 1'b0;
              if (freq == MAX_W) begin
                dds_en     <= 1'b0;
                sweep_done <= 1'b1;
              end else begin
                dds_en <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            dds_en     <= 1'b0;
            sweep_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sweep_freq_gen.sv
// tb/tb_sweep_freq_gen.sv - self-checking bench for sweep_freq_gen
module tb_sweep_freq_gen;

  logic        clk_50m = 1'b0;
  logic        rst_n = 1'b0;
  logic        learn_en = 1'b0;
  logic        next_freq = 1'b0;
  logic        next_freq2 = 1'b0;
  logic [15:0] freq, freq2;
  logic [31:0] ftw, ftw2;
  logic        ftw_valid, ftw_valid2;
  logic        dds_en, dds_en2;
  logic        sweep_done, sweep_done2;

  int n_checks = 0;
  int n_fail = 0;
  int vcnt1 = 0;
  int vcnt2 = 0;

  always #10 clk_50m = ~clk_50m;

  sweep_freq_gen dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .learn_en   (learn_en),
    .next_freq  (next_freq),
    .freq       (freq),
    .ftw        (ftw),
    .ftw_valid  (ftw_valid),
    .dds_en     (dds_en),
    .sweep_done (sweep_done)
  );

  sweep_freq_gen #(.START_INDEX(2748), .STEP(7)) dut_step7 (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .learn_en   (learn_en),
    .next_freq  (next_freq2),
    .freq       (freq2),
    .ftw        (ftw2),
    .ftw_valid  (ftw_valid2),
    .dds_en     (dds_en2),
    .sweep_done (sweep_done2)
  );

  always @(posedge clk_50m) begin
    #1;
    if (ftw_valid)  vcnt1++;
    if (ftw_valid2) vcnt2++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_next(input int which, input logic v);
    if (which == 0) next_freq = v;
    else            next_freq2 = v;
  endtask

  task automatic pulse(input int which, input bit expect_upd);
    int c0;
    int t;
    c0 = (which == 0) ? vcnt1 : vcnt2;
    drive_next(which, 1'b1);
    repeat (3) @(negedge clk_50m);
    drive_next(which, 1'b0);
    if (expect_upd) begin
      t = 0;
      while (((which == 0) ? vcnt1 : vcnt2) == c0 && t < 20) begin
        @(negedge clk_50m);
        t++;
      end
      chk("pulse_update_count", ((which == 0) ? vcnt1 : vcnt2) - c0, 1);
    end else begin
      repeat (12) @(negedge clk_50m);
      chk("pulse_no_update", ((which == 0) ? vcnt1 : vcnt2) - c0, 0);
    end
    repeat (3) @(negedge clk_50m);
  endtask

  typedef struct {
    int freq;
    int ftw;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;

    vecs[0] = '{2, 68720};
    vecs[1] = '{3, 103080};
    vecs[2] = '{4, 137440};
    vecs[3] = '{5, 171800};
    vecs[4] = '{6, 206160};

    repeat (3) @(negedge clk_50m);
    chk("reset_freq", freq, 0);
    chk("reset_ftw", ftw, 0);
    chk("reset_flags", {ftw_valid, dds_en, sweep_done}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50m);
    learn_en = 1'b1;
    repeat (6) @(negedge clk_50m);
    chk("idle_hold_freq", freq, 0);
    chk("idle_hold_dds", dds_en, 0);

    // Saturating step on the STEP=7 instance.
    pulse(1, 1'b1);
    chk("s7_freq_first", freq2, 2748);
    chk("s7_ftw_first", ftw2, 94421280);
    chk("s7_dds_first", dds_en2, 1);
    pulse(1, 1'b1);
    chk("s7_freq_sat", freq2, 2751);
    chk("s7_ftw_sat", ftw2, 94524360);
    chk("s7_done", sweep_done2, 1);
    chk("s7_dds_off", dds_en2, 0);

    // First pulse with exact latency.
    c0 = vcnt1;
    next_freq = 1'b1;
    repeat (3) @(negedge clk_50m);
    chk("lat_freq_before", freq, 0);
    next_freq = 1'b0;
    @(negedge clk_50m);
    chk("lat_freq_edge4", freq, 1);
    @(negedge clk_50m);
    chk("lat_ftw_early", ftw, 0);
    chk("lat_valid_early", ftw_valid, 0);
    @(negedge clk_50m);
    chk("lat_ftw", ftw, 34360);
    chk("lat_valid", ftw_valid, 1);
    chk("lat_dds_en", dds_en, 1);
    @(negedge clk_50m);
    chk("lat_valid_one_cycle", ftw_valid, 0);
    repeat (4) @(negedge clk_50m);
    chk("lat_valid_count", vcnt1 - c0, 1);

    for (int i = 0; i < 5; i++) begin
      pulse(0, 1'b1);
      chk("vec_freq", freq, vecs[i].freq);
      chk("vec_ftw", ftw, vecs[i].ftw);
      chk("vec_dds_en", dds_en, 1);
      chk("vec_done", sweep_done, 0);
    end

    // Second edge lands in the last CALC cycle and is served from pending.
    c0 = vcnt1;
    next_freq = 1'b1;
    @(negedge clk_50m);
    next_freq = 1'b0;
    @(negedge clk_50m);
    next_freq = 1'b1;
    @(negedge clk_50m);
    next_freq = 1'b0;
    repeat (20) @(negedge clk_50m);
    chk("pend_freq", freq, 8);
    chk("pend_ftw", ftw, 274880);
    chk("pend_valid_count", vcnt1 - c0, 2);

    n = 0;
    while (freq != 16'd2751 && n < 3000) begin
      pulse(0, 1'b1);
      n++;
    end
    chk("sweep_freq_end", freq, 2751);
    chk("sweep_ftw_end", ftw, 94524360);
    chk("sweep_done", sweep_done, 1);
    chk("sweep_dds_off", dds_en, 0);

    pulse(0, 1'b0);
    chk("done_freq_hold", freq, 2751);
    chk("done_ftw_hold", ftw, 94524360);
    chk("done_stays", sweep_done, 1);

    learn_en = 1'b0;
    repeat (5) @(negedge clk_50m);
    chk("learn_off_freq", freq, 0);
    chk("learn_off_ftw", ftw, 0);
    chk("learn_off_done", sweep_done, 0);

    // Abort an in-flight CALC by dropping learn_en.
    learn_en = 1'b1;
    repeat (5) @(negedge clk_50m);
    c0 = vcnt1;
    next_freq = 1'b1;
    repeat (3) @(negedge clk_50m);
    learn_en = 1'b0;
    next_freq = 1'b0;
    @(negedge clk_50m);
    chk("abort_in_calc_freq", freq, 1);
    repeat (2) @(negedge clk_50m);
    chk("abort_freq", freq, 0);
    chk("abort_ftw", ftw, 0);
    chk("abort_dds", dds_en, 0);
    repeat (8) @(negedge clk_50m);
    chk("abort_no_valid", vcnt1 - c0, 0);

    // next_freq already high when learn_en rises is not a request.
    next_freq = 1'b1;
    repeat (6) @(negedge clk_50m);
    learn_en = 1'b1;
    repeat (10) @(negedge clk_50m);
    chk("held_high_freq", freq, 0);
    next_freq = 1'b0;
    repeat (4) @(negedge clk_50m);
    pulse(0, 1'b1);
    chk("held_high_next_edge", freq, 1);

    // Asynchronous reset mid-sweep.
    @(posedge clk_50m);
    #3 rst_n = 1'b0;
    #2;
    chk("async_rst_freq", freq, 0);
    chk("async_rst_dds", dds_en, 0);
    @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (6) @(negedge clk_50m);
    chk("post_rst_freq", freq, 0);
    pulse(0, 1'b1);
    chk("post_rst_restart", freq, 1);
    chk("post_rst_ftw", ftw, 34360);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sweep_freq_gen.md
SWEEP_FREQ_GEN -- requirements
Module: sweep_freq_gen

Interface
REQ-001 SHALL have parameter START_INDEX, default 1, meaning the first FFT bin index of the sweep.
REQ-002 SHALL have parameter STEP, default 1, meaning the bin increment per next_freq request.
REQ-003 SHALL have parameter INDEX_MAX, default 2751, meaning the last bin index (end of sweep).
REQ-004 SHALL have parameter FTW_PER_BIN, default 34360, meaning the 32-bit DDS tuning word for one bin (400 Hz at 50 MHz, 2^32 phase).
REQ-005 SHALL have port clk_50m, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port learn_en, input, 1 bit: sweep enable level; asynchronous to clk_50m.
REQ-008 SHALL have port next_freq, input, 1 bit: step request; a rising edge is a request; asynchronous to clk_50m.
REQ-009 SHALL have port freq, output, 16 bits: current bin index, consumed by the learning controller.
REQ-010 SHALL have port ftw, output, 32 bits: DDS frequency tuning word.
REQ-011 SHALL have port ftw_valid, output, 1 bit: one-cycle pulse when ftw updates.
REQ-012 SHALL have port dds_en, output, 1 bit: DDS output enable.
REQ-013 SHALL have port sweep_done, output, 1 bit: level, high once INDEX_MAX is reached.

Function
REQ-014 SHALL synchronise learn_en and next_freq through two flops each; next_freq SHALL use a third flop for rising-edge detection (edge = sync2 & ~sync3).
REQ-015 SHALL implement states IDLE, HOLD, CALC, DONE.
REQ-016 IDLE: freq=0, ftw=0, dds_en=0, sweep_done=0; go to HOLD when synchronised learn_en=1.
REQ-017 HOLD: on an edge, freq <= (freq==0 ? START_INDEX : freq+STEP), then go to CALC.
REQ-018 The freq update SHALL saturate: if freq+STEP >= INDEX_MAX, freq <= INDEX_MAX.
REQ-019 CALC SHALL last exactly 2 cycles (registered multiply): ftw <= low 32 bits of freq*FTW_PER_BIN.
REQ-020 ftw_valid SHALL pulse for one cycle when ftw updates.
REQ-021 dds_en SHALL go to 1 on the first ftw update.
REQ-022 After CALC, SHALL go to DONE if freq==INDEX_MAX, otherwise to HOLD.
REQ-023 An edge arriving during CALC SHALL be latched as pending (depth 1) and served on the first HOLD cycle; further edges during the same CALC SHALL be dropped.
REQ-024 DONE: sweep_done=1, dds_en=0; freq and ftw hold; edges are ignored.
REQ-025 Latency: freq SHALL change on the 4th clk_50m edge after next_freq is first sampled high; ftw and ftw_valid SHALL follow 2 cycles later.
REQ-026 Synchronised learn_en=0 in any state SHALL force IDLE on the next cycle and clear all outputs, aborting any in-flight CALC with no ftw_valid pulse.
REQ-027 A next_freq level already high at learn_en rise SHALL NOT count as an edge.

Reset
REQ-028 While rst_n=0: state=IDLE, all sync/edge flops 0, pending=0, freq=0, ftw=0, ftw_valid=0, dds_en=0, sweep_done=0.
REQ-029 Reset assertion mid-sweep SHALL take effect immediately (asynchronously); release SHALL restart from IDLE.

Structure
REQ-030 Package sweep_pkg SHALL hold the state encoding and the default values of START_INDEX, STEP, INDEX_MAX and FTW_PER_BIN.
REQ-031 Sub-module sync_edge_det (2-flop sync, level and rising-edge outputs) SHALL be instantiated for learn_en and next_freq.

Verification
REQ-032 learn_en=1, one next_freq pulse -> freq=1, then ftw=34360 with one ftw_valid pulse and dds_en=1.
REQ-033 Pulse repeatedly until INDEX_MAX -> freq=2751, ftw=94,524,360 (2751*34360), sweep_done=1, dds_en=0; an extra pulse changes nothing.
REQ-034 STEP=7, freq=2748, one pulse -> freq saturates at 2751, DONE.
REQ-035 Two edges 1 cycle apart during CALC -> exactly one extra increment; no lost or double pulse beyond one pending.
REQ-036 learn_en dropped during CALC -> IDLE within 3 cycles, freq=0, ftw=0, no ftw_valid pulse.
REQ-037 next_freq held high before learn_en rises -> freq stays 0 until the next 0->1 transition of next_freq.
